// File: rtl/aclk_key_buffer_pkg.sv
// Shared constants and command decode for the alarm-clock key-entry path.
// Digit limits for a 24h HH:MM entry and the command priority used by the key buffer.
package aclk_key_buffer_pkg;

  localparam int KEY_MAX_DIGIT  = 9;
  localparam int MS_HR_MAX      = 2;
  localparam int LS_HR_MAX_AT_2 = 3;
  localparam int MS_MIN_MAX     = 5;

  typedef enum logic [1:0] {
    CMD_NONE,
    CMD_CLEAR,
    CMD_SHIFT,
    CMD_BACK
  } cmd_e;

  // clear wins over shift, shift wins over backspace
  function automatic cmd_e decode_cmd(input logic shift, input logic backspace,
                                      input logic clear);
    if (clear)     return CMD_CLEAR;
    if (shift)     return CMD_SHIFT;
    if (backspace) return CMD_BACK;
    return CMD_NONE;
  endfunction

endpackage

// File: rtl/aclk_time_check.sv
// Combinational HH:MM validator for four BCD digits.
// Also used by the alarm compare path, so it has no clock and no state.
module aclk_time_check
  import aclk_key_buffer_pkg::*;
#(
  parameter int DIGIT_W = 4
) (
  input  logic [DIGIT_W-1:0] ms_hr,
  input  logic [DIGIT_W-1:0] ls_hr,
  input  logic [DIGIT_W-1:0] ms_min,
  input  logic [DIGIT_W-1:0] ls_min,
  output logic               hhmm_ok
);

  logic hr_ok;
  logic min_ok;

  always_comb begin
    if (ms_hr < DIGIT_W'(MS_HR_MAX)) begin
      hr_ok = (ls_hr <= DIGIT_W'(KEY_MAX_DIGIT));
    end else begin
      hr_ok = (ms_hr == DIGIT_W'(MS_HR_MAX)) && (ls_hr <= DIGIT_W'(LS_HR_MAX_AT_2));
    end
    min_ok  = (ms_min <= DIGIT_W'(MS_MIN_MAX)) && (ls_min <= DIGIT_W'(KEY_MAX_DIGIT));
    hhmm_ok = hr_ok && min_ok;
  end

endmodule

// File: rtl/aclk_key_buffer.sv
// Key-entry buffer: keeps the last DEPTH BCD digits, newest in slot 0, with
// backspace, clear, fill count, flags, illegal-key rejection and HH:MM validity.
module aclk_key_buffer
  import aclk_key_buffer_pkg::*;
#(
  parameter  int DIGIT_W     = 4,
  parameter  int DEPTH       = 4,
  parameter  int DROP_OLDEST = 1,
  parameter  int TIME_CHECK  = 1,
  localparam int CNT_W       = $clog2(DEPTH + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     shift,
  input  logic                     backspace,
  input  logic                     clear,
  input  logic [DIGIT_W-1:0]       key,
  output logic [DEPTH*DIGIT_W-1:0] buffer_out,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     empty,
  output logic                     entry_valid,
  output logic                     key_err
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  cmd_e                     cmd;
  logic                     key_ok;
  logic                     at_full;
  logic                     do_push;
  logic                     do_pop;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic                     valid_q, valid_d;
  logic                     key_err_q, key_err_d;
  logic [DEPTH*DIGIT_W-1:0] slots_q, slots_d;

  always_comb begin
    cmd     = decode_cmd(shift, backspace, clear);
    key_ok  = (key <= DIGIT_W'(KEY_MAX_DIGIT));
    at_full = (count_q == DEPTH_C);
    // a push at full only happens when the oldest digit may be dropped
    do_push   = (cmd == CMD_SHIFT) && key_ok && (!at_full || (DROP_OLDEST != 0));
    do_pop    = (cmd == CMD_BACK) && (count_q != '0);
    key_err_d = (cmd == CMD_SHIFT) && !do_push;

    count_d = count_q;
    if (cmd == CMD_CLEAR) begin
      count_d = '0;
    end else if (do_push && !at_full) begin
      count_d = count_q + 1'b1;
    end else if (do_pop) begin
      count_d = count_q - 1'b1;
    end
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    logic [DIGIT_W-1:0] push_src;
    logic [DIGIT_W-1:0] pop_src;
    logic [DIGIT_W-1:0] slot_q, slot_d;

    if (i == 0) begin : g_first
      assign push_src = key;
    end else begin : g_upper
      assign push_src = slots_q[(i-1)*DIGIT_W +: DIGIT_W];
    end

    if (i == DEPTH - 1) begin : g_top
      assign pop_src = '0;
    end else begin : g_below
      assign pop_src = slots_q[(i+1)*DIGIT_W +: DIGIT_W];
    end

    always_comb begin
      slot_d = slot_q;
      if (cmd == CMD_CLEAR) begin
        slot_d = '0;
      end else if (do_push) begin
        slot_d = push_src;
      end else if (do_pop) begin
        slot_d = pop_src;
      end
    end

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        slot_q <= '0;
      end else begin
        slot_q <= slot_d;
      end
    end

    assign slots_q[i*DIGIT_W +: DIGIT_W] = slot_q;
    assign slots_d[i*DIGIT_W +: DIGIT_W] = slot_d;
  end

  // Validity is judged on next-state digits so it lands in the same cycle as full.
  if ((TIME_CHECK != 0) && (DEPTH == 4)) begin : g_time
    logic hhmm_ok;

    aclk_time_check #(
      .DIGIT_W (DIGIT_W)
    ) u_time_check (
      .ms_hr   (slots_d[3*DIGIT_W +: DIGIT_W]),
      .ls_hr   (slots_d[2*DIGIT_W +: DIGIT_W]),
      .ms_min  (slots_d[1*DIGIT_W +: DIGIT_W]),
      .ls_min  (slots_d[0*DIGIT_W +: DIGIT_W]),
      .hhmm_ok (hhmm_ok)
    );

    assign valid_d = full_d && hhmm_ok;
  end else begin : g_no_time
    assign valid_d = full_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      valid_q   <= 1'b0;
      key_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      valid_q   <= valid_d;
      key_err_q <= key_err_d;
    end
  end

  assign buffer_out  = slots_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign entry_valid = valid_q;
  assign key_err     = key_err_q;

endmodule

// File: tb/tb_aclk_key_buffer.sv
// Bench for aclk_key_buffer: three configurations share one command stream and are
// compared against a digit-list reference model (newest digit at the queue front).
module tb_aclk_key_buffer;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic       shift     = 1'b0;
  logic       backspace = 1'b0;
  logic       clear     = 1'b0;
  logic [3:0] key       = 4'd0;

  // a: DEPTH 4 drop-oldest, b: DEPTH 4 refuse-when-full, c: DEPTH 6
  logic [15:0] buf_a, buf_b;
  logic [23:0] buf_c;
  logic [2:0]  cnt_a, cnt_b, cnt_c;
  logic        full_a, full_b, full_c;
  logic        empty_a, empty_b, empty_c;
  logic        val_a, val_b, val_c;
  logic        err_a, err_b, err_c;

  aclk_key_buffer #(.DIGIT_W(4), .DEPTH(4), .DROP_OLDEST(1), .TIME_CHECK(1)) u_a (
    .clock(clock), .reset(reset), .shift(shift), .backspace(backspace), .clear(clear),
    .key(key), .buffer_out(buf_a), .count(cnt_a), .full(full_a), .empty(empty_a),
    .entry_valid(val_a), .key_err(err_a));

  aclk_key_buffer #(.DIGIT_W(4), .DEPTH(4), .DROP_OLDEST(0), .TIME_CHECK(1)) u_b (
    .clock(clock), .reset(reset), .shift(shift), .backspace(backspace), .clear(clear),
    .key(key), .buffer_out(buf_b), .count(cnt_b), .full(full_b), .empty(empty_b),
    .entry_valid(val_b), .key_err(err_b));

  aclk_key_buffer #(.DIGIT_W(4), .DEPTH(6), .DROP_OLDEST(1), .TIME_CHECK(1)) u_c (
    .clock(clock), .reset(reset), .shift(shift), .backspace(backspace), .clear(clear),
    .key(key), .buffer_out(buf_c), .count(cnt_c), .full(full_c), .empty(empty_c),
    .entry_valid(val_c), .key_err(err_c));

  logic [23:0] act_buf [3];
  logic [2:0]  act_cnt [3];
  logic        act_full[3], act_empty[3], act_val[3], act_err[3];

  assign act_buf[0] = {8'h00, buf_a};
  assign act_buf[1] = {8'h00, buf_b};
  assign act_buf[2] = buf_c;
  assign act_cnt[0] = cnt_a;   assign act_cnt[1] = cnt_b;   assign act_cnt[2] = cnt_c;
  assign act_full[0] = full_a; assign act_full[1] = full_b; assign act_full[2] = full_c;
  assign act_empty[0] = empty_a; assign act_empty[1] = empty_b; assign act_empty[2] = empty_c;
  assign act_val[0] = val_a;   assign act_val[1] = val_b;   assign act_val[2] = val_c;
  assign act_err[0] = err_a;   assign act_err[1] = err_b;   assign act_err[2] = err_c;

  // ---------------- scoreboard / reference model ----------------
  int         tests = 0;
  int         fails = 0;
  logic [3:0] exp_q [3][$];
  logic       exp_err [3];
  int         depth_of [3] = '{4, 4, 6};
  int         drop_of  [3] = '{1, 0, 1};

  task automatic model_step(input logic sh, input logic bs, input logic cl,
                            input logic [3:0] k);
    for (int d = 0; d < 3; d++) begin
      exp_err[d] = 1'b0;
      if (cl) begin
        exp_q[d].delete();
      end else if (sh) begin
        if (k > 4'd9) begin
          exp_err[d] = 1'b1;
        end else if (exp_q[d].size() < depth_of[d]) begin
          exp_q[d].push_front(k);
        end else if (drop_of[d] != 0) begin
          void'(exp_q[d].pop_back());
          exp_q[d].push_front(k);
        end else begin
          exp_err[d] = 1'b1;
        end
      end else if (bs && exp_q[d].size() > 0) begin
        void'(exp_q[d].pop_front());
      end
    end
  endtask

  function automatic logic [23:0] exp_buf(input int d);
    logic [23:0] v;
    v = '0;
    for (int i = 0; i < exp_q[d].size(); i++) v = v | (24'(exp_q[d][i]) << (4 * i));
    return v;
  endfunction

  function automatic logic exp_valid(input int d);
    int hh, mm;
    if (exp_q[d].size() != depth_of[d]) return 1'b0;
    if (depth_of[d] != 4) return 1'b1;
    hh = int'(exp_q[d][3]) * 10 + int'(exp_q[d][2]);
    mm = int'(exp_q[d][1]) * 10 + int'(exp_q[d][0]);
    return (hh < 24) && (mm < 60);
  endfunction

  // ---------------- driver tasks (called at a negedge, return at a negedge) -------
  task automatic drive(input logic sh, input logic bs, input logic cl, input logic [3:0] k);
    shift = sh; backspace = bs; clear = cl; key = k;
    @(posedge clock);
    model_step(sh, bs, cl, k);
    @(negedge clock);
    shift = 1'b0; backspace = 1'b0; clear = 1'b0;
  endtask

  task automatic push(input logic [3:0] k);
    drive(1'b1, 1'b0, 1'b0, k);
  endtask

  // ---------------- test scenarios ----------------
  task automatic test_reset;
    #1 reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    for (int d = 0; d < 3; d++) exp_q[d].delete();
    tests++; if (buf_a !== 16'h0000) begin fails++; $display("FAIL reset_buf: got %h want 0000", buf_a); end
    tests++; if (cnt_a !== 3'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", cnt_a); end
    tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", empty_a); end
    tests++; if (full_a !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full_a); end
    tests++; if (val_a !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", val_a); end
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL reset_key_err: got %b want 0", err_a); end
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_fill;
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    tests++; if (buf_a !== 16'h1234) begin fails++; $display("FAIL fill_buf: got %h want 1234", buf_a); end
    tests++; if (cnt_a !== 3'd4) begin fails++; $display("FAIL fill_count: got %0d want 4", cnt_a); end
    tests++; if (full_a !== 1'b1) begin fails++; $display("FAIL fill_full: got %b want 1", full_a); end
    tests++; if (val_a !== 1'b1) begin fails++; $display("FAIL fill_valid: got %b want 1", val_a); end
  endtask

  task automatic test_drop_oldest;
    push(4'd5);
    tests++; if (buf_a !== 16'h2345) begin fails++; $display("FAIL drop_buf: got %h want 2345", buf_a); end
    tests++; if (cnt_a !== 3'd4) begin fails++; $display("FAIL drop_count: got %0d want 4", cnt_a); end
    tests++; if (val_a !== 1'b1) begin fails++; $display("FAIL drop_valid_2345: got %b want 1", val_a); end
    tests++; if (buf_b !== 16'h1234) begin fails++; $display("FAIL refuse_buf: got %h want 1234", buf_b); end
    tests++; if (err_b !== 1'b1) begin fails++; $display("FAIL refuse_key_err: got %b want 1", err_b); end
    push(4'd9);
    tests++; if (buf_a !== 16'h3459) begin fails++; $display("FAIL drop_buf2: got %h want 3459", buf_a); end
    tests++; if (val_a !== 1'b0) begin fails++; $display("FAIL drop_valid_3459: got %b want 0", val_a); end
  endtask

  task automatic test_backspace;
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    push(4'd1); push(4'd2); push(4'd3); push(4'd4);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    drive(1'b0, 1'b1, 1'b0, 4'd0);
    tests++; if (buf_a !== 16'h0012) begin fails++; $display("FAIL bs_buf: got %h want 0012", buf_a); end
    tests++; if (cnt_a !== 3'd2) begin fails++; $display("FAIL bs_count: got %0d want 2", cnt_a); end
    tests++; if (full_a !== 1'b0) begin fails++; $display("FAIL bs_full: got %b want 0", full_a); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 4'd0);
      tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL bs_key_err: got %b want 0", err_a); end
    end
    tests++; if (buf_a !== 16'h0000) begin fails++; $display("FAIL bs_empty_buf: got %h want 0000", buf_a); end
    tests++; if (cnt_a !== 3'd0) begin fails++; $display("FAIL bs_empty_count: got %0d want 0", cnt_a); end
    tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL bs_empty_flag: got %b want 1", empty_a); end
  endtask

  task automatic test_illegal_key;
    push(4'd3);
    push(4'hB);
    tests++; if (buf_a !== 16'h0003) begin fails++; $display("FAIL illegal_buf: got %h want 0003", buf_a); end
    tests++; if (cnt_a !== 3'd1) begin fails++; $display("FAIL illegal_count: got %0d want 1", cnt_a); end
    tests++; if (err_a !== 1'b1) begin fails++; $display("FAIL illegal_key_err: got %b want 1", err_a); end
    drive(1'b0, 1'b0, 1'b0, 4'd0);
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL illegal_err_width: got %b want 0", err_a); end
  endtask

  task automatic test_no_drop;
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    push(4'd0); push(4'd9); push(4'd5); push(4'd9);
    push(4'd7);
    tests++; if (buf_b !== 16'h0959) begin fails++; $display("FAIL nodrop_buf: got %h want 0959", buf_b); end
    tests++; if (err_b !== 1'b1) begin fails++; $display("FAIL nodrop_key_err: got %b want 1", err_b); end
    tests++; if (cnt_b !== 3'd4) begin fails++; $display("FAIL nodrop_count: got %0d want 4", cnt_b); end
    tests++; if (buf_a !== 16'h9597) begin fails++; $display("FAIL drop_side_buf: got %h want 9597", buf_a); end
    tests++; if (err_a !== 1'b0) begin fails++; $display("FAIL drop_side_err: got %b want 0", err_a); end
  endtask

  task automatic test_priority;
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    push(4'd1); push(4'd2);
    drive(1'b1, 1'b0, 1'b1, 4'd5);
    tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL clr_shift_empty: got %b want 1", empty_a); end
    tests++; if (buf_a !== 16'h0000) begin fails++; $display("FAIL clr_shift_buf: got %h want 0000", buf_a); end
    push(4'd1); push(4'd2);
    drive(1'b1, 1'b1, 1'b0, 4'd7);
    tests++; if (buf_a !== 16'h0127) begin fails++; $display("FAIL shift_bs_buf: got %h want 0127", buf_a); end
    tests++; if (cnt_a !== 3'd3) begin fails++; $display("FAIL shift_bs_count: got %0d want 3", cnt_a); end
  endtask

  task automatic test_reset_mid;
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    push(4'd1); push(4'd2); push(4'd3);
    #2 reset = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) exp_q[d].delete();
    tests++; if (buf_a !== 16'h0000) begin fails++; $display("FAIL midrst_buf: got %h want 0000", buf_a); end
    tests++; if (cnt_a !== 3'd0) begin fails++; $display("FAIL midrst_count: got %0d want 0", cnt_a); end
    tests++; if (empty_a !== 1'b1) begin fails++; $display("FAIL midrst_empty: got %b want 1", empty_a); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    push(4'd8);
    tests++; if (buf_a !== 16'h0008) begin fails++; $display("FAIL after_rst_buf: got %h want 0008", buf_a); end
    tests++; if (cnt_a !== 3'd1) begin fails++; $display("FAIL after_rst_count: got %0d want 1", cnt_a); end
  endtask

  task automatic test_depth6;
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) push(4'd9);
    tests++; if (val_a !== 1'b0) begin fails++; $display("FAIL d4_9999_valid: got %b want 0", val_a); end
    tests++; if (full_c !== 1'b0) begin fails++; $display("FAIL d6_full_early: got %b want 0", full_c); end
    tests++; if (val_c !== 1'b0) begin fails++; $display("FAIL d6_valid_early: got %b want 0", val_c); end
    push(4'd9); push(4'd9);
    tests++; if (buf_c !== 24'h999999) begin fails++; $display("FAIL d6_buf: got %h want 999999", buf_c); end
    tests++; if (full_c !== 1'b1) begin fails++; $display("FAIL d6_full: got %b want 1", full_c); end
    tests++; if (val_c !== 1'b1) begin fails++; $display("FAIL d6_valid: got %b want 1", val_c); end
  endtask

  task automatic test_random;
    logic       sh, bs, cl;
    logic [3:0] k;
    drive(1'b0, 1'b0, 1'b1, 4'd0);
    for (int n = 0; n < 400; n++) begin
      cl = ($urandom_range(0, 19) == 0);
      sh = ($urandom_range(0, 9) < 6);
      bs = ($urandom_range(0, 9) < 3);
      if ($urandom_range(0, 7) == 0) k = 4'($urandom_range(10, 15));
      else k = 4'($urandom_range(0, 9));
      drive(sh, bs, cl, k);
      for (int d = 0; d < 3; d++) begin
        tests++;
        if (act_buf[d] !== exp_buf(d)) begin
          fails++; $display("FAIL rnd_buf[%0d]: got %h want %h", d, act_buf[d], exp_buf(d));
        end
        tests++;
        if (act_cnt[d] !== 3'(exp_q[d].size())) begin
          fails++; $display("FAIL rnd_count[%0d]: got %0d want %0d", d, act_cnt[d], exp_q[d].size());
        end
        tests++;
        if (act_full[d] !== (exp_q[d].size() == depth_of[d])) begin
          fails++; $display("FAIL rnd_full[%0d]: got %b", d, act_full[d]);
        end
        tests++;
        if (act_empty[d] !== (exp_q[d].size() == 0)) begin
          fails++; $display("FAIL rnd_empty[%0d]: got %b", d, act_empty[d]);
        end
        tests++;
        if (act_val[d] !== exp_valid(d)) begin
          fails++; $display("FAIL rnd_valid[%0d]: got %b want %b", d, act_val[d], exp_valid(d));
        end
        tests++;
        if (act_err[d] !== exp_err[d]) begin
          fails++; $display("FAIL rnd_key_err[%0d]: got %b want %b", d, act_err[d], exp_err[d]);
        end
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    test_fill();
    test_drop_oldest();
    test_backspace();
    test_illegal_key();
    test_no_drop();
    test_priority();
    test_reset_mid();
    test_depth6();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
